// File: rtl/pwr_switch_ack_model.sv
// Per-domain power-switch acknowledge model: returns ack_n after programmable on/off latencies,
// with abort-on-revert and runtime latency writes. Optional jitter: define PWR_SW_JITTER_EN.
module pwr_switch_ack_model #(
    parameter int                NUM_CH      = 4,
    parameter int                LAT_W       = 6,
    parameter logic [LAT_W-1:0]  ON_LAT_DEF  = 15,
    parameter logic [LAT_W-1:0]  OFF_LAT_DEF = 15,
    parameter logic [NUM_CH-1:0] ACK_RST_VAL = '0,
    parameter logic [7:0]        LFSR_SEED   = 8'hA5,
    localparam int               CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_CH-1:0] switch_n_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [LAT_W-1:0]  cfg_on_lat_i,
    input  logic [LAT_W-1:0]  cfg_off_lat_i,
    output logic [NUM_CH-1:0] ack_n_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] abort_o
);

`ifdef PWR_SW_JITTER_EN
    localparam int CNT_W = LAT_W + 1;
`else
    localparam int CNT_W = LAT_W;
`endif

    typedef enum logic {S_IDLE, S_RAMP} state_e;

    state_e            state_q   [NUM_CH];
    state_e            state_d   [NUM_CH];
    logic [CNT_W-1:0]  cnt_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_d     [NUM_CH];
    logic [CNT_W-1:0]  lat_q     [NUM_CH];
    logic [CNT_W-1:0]  lat_d     [NUM_CH];
    logic [LAT_W-1:0]  on_lat_q  [NUM_CH];
    logic [LAT_W-1:0]  on_lat_d  [NUM_CH];
    logic [LAT_W-1:0]  off_lat_q [NUM_CH];
    logic [LAT_W-1:0]  off_lat_d [NUM_CH];
    logic [NUM_CH-1:0] tgt_q, tgt_d;
    logic [NUM_CH-1:0] ack_q, ack_d;
    logic [NUM_CH-1:0] abort_q, abort_d;
    logic [2:0]        jitter;

`ifdef PWR_SW_JITTER_EN
    logic [7:0] lfsr_q;

    // Fibonacci LFSR, taps 8,6,5,4; shared by all channels so simultaneous entries see the same jitter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    assign jitter = lfsr_q[2:0];
`else
    assign jitter = 3'd0;
`endif

    // A programmed latency of 0 behaves as 1 so ack is always at least one register away from switch_n.
    function automatic logic [CNT_W-1:0] eff_lat(input logic [LAT_W-1:0] base, input logic [2:0] jit);
        logic [CNT_W-1:0] b;
        b = (base == '0) ? CNT_W'(1) : CNT_W'(base);
        return b + CNT_W'(jit);
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c]   = state_q[c];
            cnt_d[c]     = cnt_q[c];
            lat_d[c]     = lat_q[c];
            on_lat_d[c]  = on_lat_q[c];
            off_lat_d[c] = off_lat_q[c];
        end
        tgt_d   = tgt_q;
        ack_d   = ack_q;
        abort_d = '0;

        for (int c = 0; c < NUM_CH; c++) begin
            case (state_q[c])
                S_IDLE: begin
                    if (switch_n_i[c] != ack_q[c]) begin
                        state_d[c] = S_RAMP;
                        tgt_d[c]   = switch_n_i[c];
                        lat_d[c]   = eff_lat(switch_n_i[c] ? off_lat_q[c] : on_lat_q[c], jitter);
                        cnt_d[c]   = CNT_W'(1);
                    end
                end
                S_RAMP: begin
                    // Revert wins over completion: a request withdrawn on the final edge still aborts.
                    if (switch_n_i[c] == ack_q[c]) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                        abort_d[c] = 1'b1;
                    end else if (cnt_q[c] == lat_q[c]) begin
                        state_d[c] = S_IDLE;
                        cnt_d[c]   = '0;
                        ack_d[c]   = tgt_q[c];
                    end else begin
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end
                end
                default: state_d[c] = S_IDLE;
            endcase
        end

        if (cfg_we_i && (32'(cfg_ch_i) < NUM_CH)) begin
            on_lat_d[cfg_ch_i]  = cfg_on_lat_i;
            off_lat_d[cfg_ch_i] = cfg_off_lat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= S_IDLE;
                cnt_q[c]     <= '0;
                lat_q[c]     <= '0;
                on_lat_q[c]  <= ON_LAT_DEF;
                off_lat_q[c] <= OFF_LAT_DEF;
            end
            tgt_q   <= ACK_RST_VAL;
            ack_q   <= ACK_RST_VAL;
            abort_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c]   <= state_d[c];
                cnt_q[c]     <= cnt_d[c];
                lat_q[c]     <= lat_d[c];
                on_lat_q[c]  <= on_lat_d[c];
                off_lat_q[c] <= off_lat_d[c];
            end
            tgt_q   <= tgt_d;
            ack_q   <= ack_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        busy_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            busy_o[c] = (state_q[c] == S_RAMP);
        end
    end

    assign ack_n_o = ack_q;
    assign abort_o = abort_q;

endmodule

// File: tb/tb_pwr_switch_ack_model.sv
// Bench for pwr_switch_ack_model: directed latency/abort/reset scenarios plus random traffic,
// all cycles compared against a deadline-based reference model.
module tb_pwr_switch_ack_model;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [5:0] cfg_on, cfg_off;
    logic [3:0] ack, busy, abort;

    logic [4:0] sw5;
    logic       cfg_we5;
    logic [2:0] cfg_ch5;
    logic [5:0] cfg_on5, cfg_off5;
    logic [4:0] ack5, busy5, abort5;

    int checks = 0;
    int fails  = 0;

    pwr_switch_ack_model u_dut (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw_n), .cfg_we_i(cfg_we), .cfg_ch_i(cfg_ch),
        .cfg_on_lat_i(cfg_on), .cfg_off_lat_i(cfg_off),
        .ack_n_o(ack), .busy_o(busy), .abort_o(abort)
    );

    pwr_switch_ack_model #(.NUM_CH(5)) u_dut5 (
        .clk_i(clk), .rst_ni(rst_n), .switch_n_i(sw5), .cfg_we_i(cfg_we5), .cfg_ch_i(cfg_ch5),
        .cfg_on_lat_i(cfg_on5), .cfg_off_lat_i(cfg_off5),
        .ack_n_o(ack5), .busy_o(busy5), .abort_o(abort5)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: each pending request carries an absolute due edge
    int         m_on [4];
    int         m_off[4];
    bit         m_pend[4];
    longint     m_due[4];
    logic [3:0] m_tgt, m_ack, m_abort;
    logic [7:0] m_lfsr;
    longint     cyc = 0;
    logic [11:0] exp_q[$];

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_on[c] = 15; m_off[c] = 15; m_pend[c] = 0; m_due[c] = 0;
        end
        m_tgt = '0; m_ack = '0; m_abort = '0; m_lfsr = 8'hA5;
    endtask

    task automatic model_edge();
        int         jit;
        int         lat;
        logic [3:0] nab;
        logic [3:0] bsy;
        if (!rst_n) begin
            model_reset();
        end else begin
            jit = 0;
`ifdef PWR_SW_JITTER_EN
            jit    = int'(m_lfsr[2:0]);
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
            nab = '0;
            for (int c = 0; c < 4; c++) begin
                if (!m_pend[c]) begin
                    if (sw_n[c] != m_ack[c]) begin
                        lat = sw_n[c] ? m_off[c] : m_on[c];
                        if (lat == 0) lat = 1;
                        m_pend[c] = 1; m_tgt[c] = sw_n[c]; m_due[c] = cyc + lat + jit;
                    end
                end else if (sw_n[c] == m_ack[c]) begin
                    m_pend[c] = 0; nab[c] = 1'b1;
                end else if (cyc == m_due[c]) begin
                    m_pend[c] = 0; m_ack[c] = m_tgt[c];
                end
            end
            if (cfg_we) begin
                m_on[cfg_ch] = int'(cfg_on); m_off[cfg_ch] = int'(cfg_off);
            end
            m_abort = nab;
        end
        cyc++;
        for (int c = 0; c < 4; c++) bsy[c] = m_pend[c];
        exp_q.push_back({m_abort, bsy, m_ack});
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        logic [11:0] e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        e = exp_q.pop_front();
        check("ack",   32'(ack),   32'(e[3:0]));
        check("busy",  32'(busy),  32'(e[7:4]));
        check("abort", 32'(abort), 32'(e[11:8]));
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [5:0] on, input logic [5:0] off);
        cfg_we = 1'b1; cfg_ch = ch; cfg_on = on; cfg_off = off;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic run_until(input int ch, input logic val, input int budget, output int edges);
        edges = -1;
        for (int k = 0; k < budget; k++) begin
            tick();
            if (ack[ch] === val) begin
                edges = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0; sw_n = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_on = '0; cfg_off = '0;
        sw5 = '0; cfg_we5 = 1'b0; cfg_ch5 = '0; cfg_on5 = '0; cfg_off5 = '0;
        model_reset();
        repeat (3) tick();
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // default latencies: ch0 off then on, both 15 edges
        sw_n[0] = 1'b1;
        run_until(0, 1'b1, 40, n);
        check("ch0_off_lat", 32'(n), 32'd15);
        sw_n[0] = 1'b0;
        run_until(0, 1'b0, 40, n);
        check("ch0_on_lat", 32'(n), 32'd15);
        tick();

        // ch2 programmed on=3 off=9
        cfg_write(2'd2, 6'd3, 6'd9);
        sw_n[2] = 1'b1;
        run_until(2, 1'b1, 40, n);
        check("ch2_off_lat", 32'(n), 32'd9);
        sw_n[2] = 1'b0;
        run_until(2, 1'b0, 40, n);
        check("ch2_on_lat", 32'(n), 32'd3);
        tick();

        // ch1 request withdrawn at edge 5
        sw_n[1] = 1'b1;
        repeat (5) tick();
        sw_n[1] = 1'b0;
        tick();
        check("ch1_abort", 32'(abort[1]), 32'd1);
        check("ch1_busy_abort", 32'(busy[1]), 32'd0);
        tick();
        check("ch1_abort_1cyc", 32'(abort[1]), 32'd0);
        check("ch1_ack_kept", 32'(ack[1]), 32'd0);

        // ch3 latency rewritten mid-ramp: current ramp keeps 15, next uses 2
        sw_n[3] = 1'b1;
        repeat (3) tick();
        cfg_write(2'd3, 6'd2, 6'd15);
        run_until(3, 1'b1, 40, n);
        check("ch3_ramp_kept", 32'(n + 4), 32'd15);
        sw_n[3] = 1'b0;
        run_until(3, 1'b0, 40, n);
        check("ch3_new_lat", 32'(n), 32'd2);
        tick();

        // all channels together, latencies 1..4, reset at edge 2
        cfg_write(2'd0, 6'd1, 6'd1);
        cfg_write(2'd1, 6'd2, 6'd2);
        cfg_write(2'd2, 6'd3, 6'd3);
        cfg_write(2'd3, 6'd4, 6'd4);
        sw_n = 4'hF;
        tick();
        check("all_e0", 32'(ack), 32'h0);
        tick();
        check("all_e1", 32'(ack), 32'h1);
        tick();
        check("all_e2", 32'(ack), 32'h3);
        rst_n = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_abort", 32'(abort), 32'h0);
        model_reset();
        sw_n = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // latency 0 acts as 1
        cfg_write(2'd0, 6'd0, 6'd0);
        sw_n[0] = 1'b1;
        run_until(0, 1'b1, 10, n);
        check("lat0", 32'(n), 32'd1);
        sw_n[0] = 1'b0;
        run_until(0, 1'b0, 10, n);
        check("lat0_on", 32'(n), 32'd1);
        tick();

        // out-of-range channel write on a 5-channel instance changes nothing
        cfg_we5 = 1'b1; cfg_ch5 = 3'd7; cfg_on5 = 6'd2; cfg_off5 = 6'd2;
        tick();
        cfg_we5 = 1'b0;
        sw5 = 5'h1F;
        n = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ack5 === 5'h1F) begin
                n = k;
                break;
            end
        end
        check("oob_cfg_lat", 32'(n), 32'd15);
        check("oob_busy", 32'(busy5), 32'h0);
        check("oob_abort", 32'(abort5), 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 5) == 0) sw_n[c] = ~sw_n[c];
            end
            cfg_we  = ($urandom_range(0, 7) == 0);
            cfg_ch  = 2'($urandom_range(0, 3));
            cfg_on  = 6'($urandom_range(0, 12));
            cfg_off = 6'($urandom_range(0, 12));
            tick();
        end
        cfg_we = 1'b0;
        repeat (40) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
